// File: rtl/pma_region_table.sv
// pma_region_table: runtime-programmable physical-memory-attribute table.
// NrRules regions, each holding base/length/attr plus a lock bit. Lookups go
// over a valid/ready handshake with a single output register.
// Optional feature: define PMA_TABLE_ERR_LOG_EN to add a sticky miss log at
// config index NrRules and the miss_irq_o output.

// Per-rule range check. The end address uses one extra bit, so a region that
// ends exactly at 2^AddrWidth covers the top address instead of wrapping.
module pma_rule_match #(
  parameter int AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] len,
  output logic                 hit
);
  logic [AddrWidth:0] lim;
  assign lim = {1'b0, base} + {1'b0, len};
  assign hit = (len != '0) && (addr >= base) && ({1'b0, addr} < lim);
endmodule

module pma_region_table #(
  parameter int                   NrRules     = 8,
  parameter int                   AddrWidth   = 64,
  parameter logic [3:0]           DefaultAttr = 4'b0000,
  parameter logic [AddrWidth-1:0] ResetBase0  = 64'h8000_0000,
  parameter logic [AddrWidth-1:0] ResetLen0   = 64'h4000_0000,
  parameter logic [3:0]           ResetAttr0  = 4'b0111,
  localparam int IdxW = (NrRules > 1) ? $clog2(NrRules) : 1,
`ifdef PMA_TABLE_ERR_LOG_EN
  // One more index value is needed to reach the log at index NrRules.
  localparam int CfgIdxW = $clog2(NrRules + 1)
`else
  localparam int CfgIdxW = IdxW
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [CfgIdxW+1:0]   cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lookup_valid_i,
  output logic                 lookup_ready_o,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [3:0]           res_attr_o,
  output logic                 res_hit_o,
  output logic                 res_multi_o,
`ifdef PMA_TABLE_ERR_LOG_EN
  output logic                 miss_irq_o,
`endif
  output logic [IdxW-1:0]      res_idx_o
);

  logic [NrRules-1:0][AddrWidth-1:0] base_q, len_q;
  logic [NrRules-1:0][3:0]           attr_q;
  logic [NrRules-1:0]                lock_q;

  logic [CfgIdxW-1:0]   cfg_idx;
  logic [IdxW-1:0]      ridx;
  logic [1:0]           cfg_word;
  logic                 idx_ok, log_sel, log_bad, cfg_bad, rule_wr;
  logic [AddrWidth-1:0] rd_val;

  assign cfg_idx  = cfg_addr_i[CfgIdxW+1:2];
  assign ridx     = cfg_idx[IdxW-1:0];
  assign cfg_word = cfg_addr_i[1:0];
  assign idx_ok   = int'(cfg_idx) < NrRules;

`ifdef PMA_TABLE_ERR_LOG_EN
  logic                 log_vld_q, log_clr;
  logic [AddrWidth-1:0] log_addr_q;
  assign log_sel    = int'(cfg_idx) == NrRules;
  // Log is read-only except the clear via word 1; words 2/3 do not exist.
  assign log_bad    = cfg_word[1] || (cfg_we_i && cfg_word == 2'd0);
  assign log_clr    = cfg_req_i && cfg_we_i && log_sel && cfg_word == 2'd1;
  assign miss_irq_o = log_vld_q;
`else
  assign log_sel = 1'b0;
  assign log_bad = 1'b0;
`endif

  // Reject out-of-range index, reserved word, and writes to a locked rule.
  always_comb begin
    cfg_bad = 1'b0;
    if (cfg_req_i) begin
      if (log_sel)                           cfg_bad = log_bad;
      else if (!idx_ok || cfg_word == 2'd3)  cfg_bad = 1'b1;
      else if (cfg_we_i && lock_q[ridx])     cfg_bad = 1'b1;
    end
  end

  assign rule_wr = cfg_req_i && cfg_we_i && !cfg_bad && !log_sel;

  // Rule storage; rule 0 comes up as the DRAM window, the rest disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q    <= '0;
      len_q     <= '0;
      attr_q    <= '0;
      lock_q    <= '0;
      base_q[0] <= ResetBase0;
      len_q[0]  <= ResetLen0;
      attr_q[0] <= ResetAttr0;
    end else if (rule_wr) begin
      case (cfg_word)
        2'd0:    base_q[ridx] <= cfg_wdata_i;
        2'd1:    len_q[ridx]  <= cfg_wdata_i;
        2'd2: begin
          attr_q[ridx] <= cfg_wdata_i[3:0];
          lock_q[ridx] <= cfg_wdata_i[7];
        end
        default: ;
      endcase
    end
  end

  // Read mux over the addressed word.
  always_comb begin
    rd_val = '0;
    if (log_sel) begin
`ifdef PMA_TABLE_ERR_LOG_EN
      if (cfg_word == 2'd0)      rd_val = log_addr_q;
      else if (cfg_word == 2'd1) rd_val[0] = log_vld_q;
`endif
    end else if (idx_ok) begin
      case (cfg_word)
        2'd0:    rd_val = base_q[ridx];
        2'd1:    rd_val = len_q[ridx];
        2'd2: begin
          rd_val[3:0] = attr_q[ridx];
          rd_val[7]   = lock_q[ridx];
        end
        default: ;
      endcase
    end
  end

  // Config response: read data and error pulse one cycle after the access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_rdata_o <= '0;
      cfg_err_o   <= 1'b0;
    end else begin
      cfg_err_o <= cfg_bad;
      if (cfg_req_i && !cfg_we_i) cfg_rdata_o <= cfg_bad ? '0 : rd_val;
    end
  end

  logic [NrRules-1:0] hit_vec;
  logic [IdxW-1:0]    win_idx;
  logic [3:0]         win_attr;
  logic [5:0]         nhit;
  logic               any_hit, lk_fire;

  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    pma_rule_match #(.AddrWidth(AddrWidth)) u_match (
      .addr (lookup_addr_i),
      .base (base_q[g]),
      .len  (len_q[g]),
      .hit  (hit_vec[g])
    );
  end

  // Lowest-index match wins; count matches for the multi flag.
  always_comb begin
    win_idx  = '0;
    win_attr = DefaultAttr;
    nhit     = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_idx  = IdxW'(i);
        win_attr = attr_q[i];
      end
    end
    for (int i = 0; i < NrRules; i++) nhit = nhit + 6'(hit_vec[i]);
  end

  assign any_hit        = |hit_vec;
  assign lookup_ready_o = !res_valid_o || res_ready_i;
  assign lk_fire        = lookup_valid_i && lookup_ready_o;

  // Single result register: load on accept, clear valid on drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_attr_o  <= '0;
      res_hit_o   <= 1'b0;
      res_multi_o <= 1'b0;
      res_idx_o   <= '0;
    end else if (lk_fire) begin
      res_valid_o <= 1'b1;
      res_attr_o  <= win_attr;
      res_hit_o   <= any_hit;
      res_multi_o <= nhit > 6'd1;
      res_idx_o   <= win_idx;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

`ifdef PMA_TABLE_ERR_LOG_EN
  // Sticky miss log; a miss arriving with a clear is captured as the new first miss.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      log_vld_q  <= 1'b0;
      log_addr_q <= '0;
    end else if (lk_fire && !any_hit && (!log_vld_q || log_clr)) begin
      log_vld_q  <= 1'b1;
      log_addr_q <= lookup_addr_i;
    end else if (log_clr) begin
      log_vld_q  <= 1'b0;
    end
  end
`endif

endmodule
